apb_ucpd_tx_sched: RTL

- Transmit scheduler between the APB register block and the UCPD PD main FSM.
- Latches software TXSEND and TXHRST commands and arbitrates between them (hard reset has priority).
- Enforces the inter-frame gap, checks for receive activity, issues one start pulse per frame with its frame kind, and converts FSM completion signals into single-cycle status events.

---
 rtl/apb_ucpd_pkg.sv | 43 ++++
 rtl/apb_ucpd_gap_timer.sv | 26 ++
 rtl/apb_ucpd_tx_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/apb_ucpd_pkg.sv
// Shared UCPD definitions: scheduler states, frame-kind and TXMODE codes.
// Used by the transmit scheduler and the receive-side helpers.
package apb_ucpd_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GAP    = 3'd1,
      S_ARB    = 3'd2,
      S_START  = 3'd3,
      S_ACTIVE = 3'd4
   } sched_state_t;

   localparam logic [1:0] TX_KIND_MSG  = 2'd0;
   localparam logic [1:0] TX_KIND_HRST = 2'd1;
   localparam logic [1:0] TX_KIND_CRST = 2'd2;
   localparam logic [1:0] TX_KIND_BIST = 2'd3;

   localparam logic [1:0] TX_MODE_MSG  = 2'd0;
   localparam logic [1:0] TX_MODE_CRST = 2'd1;
   localparam logic [1:0] TX_MODE_BIST = 2'd2;
   localparam logic [1:0] TX_MODE_RSVD = 2'd3;

   // Scheduler control flags, cleared as a unit by reset or ucpden low.
   typedef struct packed {
      logic       msg_pend;
      logic       hrst_pend;
      logic       abort;
      logic       und;
      logic [1:0] kind;
      logic [1:0] tx_kind;
   } tx_ctl_t;

   function automatic logic [1:0] mode_to_kind(input logic [1:0] mode);
      case (mode)
         TX_MODE_CRST: return TX_KIND_CRST;
         TX_MODE_BIST: return TX_KIND_BIST;
         TX_MODE_MSG,
         TX_MODE_RSVD: return TX_KIND_MSG;
         default:      return TX_KIND_MSG;
      endcase
   endfunction

endpackage

// File: rtl/apb_ucpd_gap_timer.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
// Shared between the transmit scheduler and the receive side.
module apb_ucpd_gap_timer #(
   parameter int W = 8
) (
   input  logic         ic_clk,
   input  logic         ic_rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ic_clk or negedge ic_rst_n) begin
      if (!ic_rst_n)         cnt <= '0;
      else if (clr)          cnt <= '0;
      else if (load)         cnt <= load_val;
      else if (cnt != '0)    cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/apb_ucpd_tx_sched.sv
// UCPD transmit scheduler: latches TXSEND/TXHRST, enforces the inter-frame gap and
// issues one start per frame. Optional macro UCPD_TX_RETRY_EN retries busy-line messages.
module apb_ucpd_tx_sched
   import apb_ucpd_pkg::*;
#(
   parameter int IFRGAP_CYC = 16,
   parameter int GAP_W      = 8
`ifdef UCPD_TX_RETRY_EN
   ,
   parameter int RETRY_MAX  = 3
`endif
) (
   input  logic       ic_clk,
   input  logic       ic_rst_n,
   input  logic       ucpden,
   input  logic       txsend_req,
   input  logic       txhrst_req,
   input  logic [1:0] tx_mode,
   input  logic       rx_busy,
   input  logic       bit_clk_red,
   input  logic       tx_frame_done,
   input  logic       tx_und,
   output logic       tx_start,
   output logic [1:0] tx_kind,
   output logic       tx_abort,
   output logic       msg_sent,
   output logic       msg_disc,
   output logic       msg_abt,
   output logic       hrst_sent,
   output logic       hrst_disc,
   output logic       sched_busy
);

   sched_state_t state_q, state_d;
   tx_ctl_t      q, d;
   logic         msg_clr, hrst_clr, gap_load, gap_zero, in_abort;
   logic         start_c, sent_c, disc_c, abt_c, hsent_c, hdisc_c;

`ifdef UCPD_TX_RETRY_EN
   localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
   logic [RW-1:0] retry_q;
   logic          retry_inc, retry_clr;
`endif

   apb_ucpd_gap_timer #(.W(GAP_W)) u_gap_timer (
      .ic_clk   (ic_clk),
      .ic_rst_n (ic_rst_n),
      .clr      (!ucpden),
      .load     (gap_load),
      .load_val (GAP_W'(IFRGAP_CYC)),
      .zero     (gap_zero)
   );

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      d         = q;
      msg_clr   = 1'b0;
      hrst_clr  = 1'b0;
      gap_load  = 1'b0;
      in_abort  = 1'b0;
      start_c   = 1'b0;
      sent_c    = 1'b0;
      disc_c    = 1'b0;
      abt_c     = 1'b0;
      hsent_c   = 1'b0;
      hdisc_c   = 1'b0;
`ifdef UCPD_TX_RETRY_EN
      retry_inc = 1'b0;
`endif
      case (state_q)
         S_IDLE:
            if (q.msg_pend || q.hrst_pend) state_d = gap_zero ? S_ARB : S_GAP;
         S_GAP:
            if (gap_zero) state_d = S_ARB;
         S_ARB: begin
            if (q.hrst_pend && rx_busy) begin
               hdisc_c  = 1'b1;
               hrst_clr = 1'b1;
               state_d  = S_IDLE;
            end else if (q.hrst_pend) begin
               d.tx_kind = TX_KIND_HRST;
               state_d   = S_START;
            end else if (q.msg_pend && rx_busy) begin
`ifdef UCPD_TX_RETRY_EN
               if (retry_q == RW'(RETRY_MAX)) begin
                  disc_c  = 1'b1;
                  msg_clr = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  retry_inc = 1'b1;
                  gap_load  = 1'b1;
                  state_d   = S_GAP;
               end
`else
               disc_c  = 1'b1;
               msg_clr = 1'b1;
               state_d = S_IDLE;
`endif
            end else if (q.msg_pend) begin
               // Message flag drops at grant so a TXSEND during the frame queues the next one.
               d.tx_kind = q.kind;
               msg_clr   = 1'b1;
               state_d   = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START:
            if (bit_clk_red) begin
               start_c = 1'b1;
               state_d = S_ACTIVE;
            end
         S_ACTIVE: begin
            in_abort = (q.tx_kind != TX_KIND_HRST) && q.hrst_pend;
            if (tx_frame_done) begin
               if (q.tx_kind == TX_KIND_HRST) begin
                  hsent_c  = 1'b1;
                  hrst_clr = 1'b1;
               end else if (q.abort || q.und || tx_und || in_abort) begin
                  abt_c = 1'b1;
               end else begin
                  sent_c = 1'b1;
               end
               gap_load = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A request seen while its own flag is still set is dropped.
      if (msg_clr)                       d.msg_pend  = 1'b0;
      else if (txsend_req)               d.msg_pend  = 1'b1;
      if (txsend_req && !q.msg_pend)     d.kind      = mode_to_kind(tx_mode);
      if (hrst_clr)                      d.hrst_pend = 1'b0;
      else if (txhrst_req)               d.hrst_pend = 1'b1;

      if (start_c) begin
         d.abort = 1'b0;
         d.und   = 1'b0;
      end else if (state_q == S_ACTIVE) begin
         if (in_abort) d.abort = 1'b1;
         if (tx_und)   d.und   = 1'b1;
      end
   end

   always_ff @(posedge ic_clk or negedge ic_rst_n) begin
      if (!ic_rst_n) begin
         state_q <= S_IDLE;
         q       <= '0;
      end else if (!ucpden) begin
         state_q <= S_IDLE;
         q       <= '0;
      end else begin
         state_q <= state_d;
         q       <= d;
      end
   end

`ifdef UCPD_TX_RETRY_EN
   assign retry_clr = sent_c | disc_c | abt_c;

   always_ff @(posedge ic_clk or negedge ic_rst_n) begin
      if (!ic_rst_n)               retry_q <= '0;
      else if (!ucpden || retry_clr) retry_q <= '0;
      else if (retry_inc)          retry_q <= retry_q + 1'b1;
   end
`endif

   assign tx_start   = ucpden & start_c;
   assign tx_kind    = ucpden ? q.tx_kind : TX_KIND_MSG;
   assign tx_abort   = ucpden & in_abort;
   assign msg_sent   = ucpden & sent_c;
   assign msg_disc   = ucpden & disc_c;
   assign msg_abt    = ucpden & abt_c;
   assign hrst_sent  = ucpden & hsent_c;
   assign hrst_disc  = ucpden & hdisc_c;
   assign sched_busy = ucpden & (state_q != S_IDLE);

endmodule
